// File: rtl/mc_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multicycle MIPS control FSM: state encoding,
// instruction opcode/funct constants and the control-field encodings that the
// datapath muxes expect.
// No ports (package).
// -----------------------------------------------------------------------------
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13,
        S_TRAP     = 4'd15
    } state_e;

    // Instruction opcodes (instruction[31:26]) and the JR funct code.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // ALUop: add, subtract (branch compare), or let the ALU decoder use funct.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // PCSource: ALU result, ALUOut (branch target), jump target, register rs.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    // ALUSrcB: register B, constant 4, sign-extended imm, shifted imm.
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BOFF  = 2'b11;

endpackage

// File: rtl/mc_ctrl_decode.sv
// -----------------------------------------------------------------------------
// mc_ctrl_decode
// Combinational Moore decode of the control FSM state into datapath controls.
// Build option: JAL_JR_EN compiles in the JAL and JR state decodes; without it
// Jal stays 0 and PCSource never selects the register source.
// Ports:
//   state_i      current FSM state
//   mem_ready_i  memory done; only qualifies the FETCH-cycle IR/PC writes
//   PCWrite .. illegal, PCSource, ALUop, ALUSrcB   control outputs
// -----------------------------------------------------------------------------
module mc_ctrl_decode
    import mc_pkg::*;
(
    input  state_e     state_i,
    input  logic       mem_ready_i,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       Jal,
    output logic       illegal,
    output logic [1:0] PCSource,
    output logic [1:0] ALUop,
    output logic [1:0] ALUSrcB
);

    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // leaves one unassigned, which would infer a latch.
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        Jal         = 1'b0;
        illegal     = 1'b0;
        PCSource    = PCSRC_ALU;
        ALUop       = ALUOP_ADD;
        ALUSrcB     = SRCB_REG;

        case (state_i)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                // IR load and PC+4 only commit on the cycle the fetch completes.
                IRWrite = mem_ready_i;
                PCWrite = mem_ready_i;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_BOFF;
            end
            S_MEM_ADDR, S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUop   = ALUOP_FUNCT;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_I_WB: begin
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUop       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
`ifdef JAL_JR_EN
            S_JAL: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
                RegWrite = 1'b1;
                Jal      = 1'b1;
            end
            S_JR: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_REG;
            end
`endif
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
// Multicycle MIPS control unit: state register and next-state logic; the
// control outputs come from the mc_ctrl_decode sub-module.
// Build option: JAL_JR_EN enables the jal/jr paths; otherwise those encodings
// trap as illegal instructions.
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   opcode, funct        instruction fields from the instruction register
//   mem_ready            memory access completes this cycle
//   zero                 ALU zero flag (consumed by the datapath's pc_en)
//   PCWrite .. ALUSrcB   datapath control outputs
//   state_o              current state code for debug
// -----------------------------------------------------------------------------
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic [OPW-1:0] funct,
    input  logic           mem_ready,
    input  logic           zero,
    output logic           PCWrite,
    output logic           PCWriteCond,
    output logic           IorD,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           MemtoReg,
    output logic           IRWrite,
    output logic           ALUSrcA,
    output logic           RegWrite,
    output logic           RegDst,
    output logic           Jal,
    output logic           illegal,
    output logic [1:0]     PCSource,
    output logic [1:0]     ALUop,
    output logic [1:0]     ALUSrcB,
    output logic [3:0]     state_o
);

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples pre-edge values.
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == OPW'(OP_RTYPE)) begin
`ifdef JAL_JR_EN
                    state_d = (funct == OPW'(FN_JR)) ? S_JR : S_R_EXEC;
`else
                    state_d = (funct == OPW'(FN_JR)) ? S_TRAP : S_R_EXEC;
`endif
                end
                else if (opcode == OPW'(OP_LW) || opcode == OPW'(OP_SW)) state_d = S_MEM_ADDR;
                else if (opcode == OPW'(OP_BEQ))  state_d = S_BRANCH;
                else if (opcode == OPW'(OP_J))    state_d = S_JUMP;
`ifdef JAL_JR_EN
                else if (opcode == OPW'(OP_JAL))  state_d = S_JAL;
`endif
                else if (opcode == OPW'(OP_ADDI)) state_d = S_I_EXEC;
                else                              state_d = S_TRAP;
            end
            S_MEM_ADDR: begin
                if      (opcode == OPW'(OP_LW)) state_d = S_MEM_RD;
                else if (opcode == OPW'(OP_SW)) state_d = S_MEM_WR;
                else                            state_d = S_TRAP;
            end
            S_MEM_RD: if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WR: if (mem_ready) state_d = S_FETCH;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_R_EXEC: state_d = S_R_WB;
            S_I_EXEC: state_d = S_I_WB;
`ifdef JAL_JR_EN
            S_JAL, S_JR: state_d = S_FETCH;
`endif
            // TRAP is left only through reset.
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    mc_ctrl_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .Jal         (Jal),
        .illegal     (illegal),
        .PCSource    (PCSource),
        .ALUop       (ALUop),
        .ALUSrcB     (ALUSrcB)
    );

    assign state_o = state_q;

    // The datapath forms pc_en from these signals; the local copy only keeps
    // the zero port referenced in this block.
    logic unused_pc_en;
    assign unused_pc_en = PCWrite | (PCWriteCond & zero);

endmodule

// File: tb/tb_mc_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_control_fsm
// Self-checking bench for mc_control_fsm. Each driven cycle pushes the expected
// state, control vector and pc_en into a queue; a negedge process pops and
// compares against the DUT. Expected JAL/JR behaviour follows JAL_JR_EN.
// -----------------------------------------------------------------------------
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       mem_ready = 1'b0;
    logic       zero = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst, Jal, illegal;
    logic [1:0] PCSource, ALUop, ALUSrcB;
    logic [3:0] state_o;

    mc_control_fsm #(.OPW(6)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .zero(zero),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .Jal(Jal), .illegal(illegal),
        .PCSource(PCSource), .ALUop(ALUop), .ALUSrcB(ALUSrcB),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [17:0] ctrl;
        logic        pc_en;
        logic        z;
    } exp_t;

    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    string cur_test = "init";

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Control vector order:
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,
    //  RegWrite,RegDst,Jal,illegal,PCSource,ALUop,ALUSrcB}
    function automatic logic [17:0] exp_ctrl(input int st, input logic mr);
        logic pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rd, jl, ill;
        logic [1:0] pcs, aop, srcb;
        {pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rd, jl, ill} = '0;
        pcs = 2'b00; aop = 2'b00; srcb = 2'b00;
        case (st)
            0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
            1:  srcb = 2'b11;
            2:  begin srca = 1; srcb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin srca = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin srca = 1; srcb = 2'b10; end
            11: rw = 1;
            12: begin pcw = 1; pcs = 2'b10; rw = 1; jl = 1; end
            13: begin pcw = 1; pcs = 2'b11; end
            15: ill = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rd, jl, ill, pcs, aop, srcb};
    endfunction

    // One clock of stimulus; the expectation describes this cycle's outputs.
    task automatic cycle(input logic r, input logic mr, input logic z, input int st);
        exp_t e;
        rst       = r;
        mem_ready = mr;
        zero      = z;
        e.st      = 4'(st);
        e.ctrl    = exp_ctrl(st, mr);
        e.z       = z;
        e.pc_en   = e.ctrl[17] | (e.ctrl[16] & z);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
        cycle(0, 1, 0, 0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [17:0] obs;
            e   = exp_q.pop_front();
            obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                   ALUSrcA, RegWrite, RegDst, Jal, illegal, PCSource, ALUop, ALUSrcB};
            check({cur_test, ":state"}, 32'(state_o), 32'(e.st));
            check({cur_test, ":ctrl"},  32'(obs),     32'(e.ctrl));
            check({cur_test, ":pc_en"}, 32'(PCWrite | (PCWriteCond & e.z)), 32'(e.pc_en));
        end
    end

    initial begin
        @(posedge clk);
        #1;
        cur_test = "reset";
        rst = 1'b1;
        @(posedge clk);
        #1;
        cycle(0, 0, 0, 0);              // FETCH stalls without IR/PC write
        cycle(0, 0, 0, 0);

        cur_test = "addi";
        fetch(6'b001000, 6'b000000);    // IRWrite=PCWrite=1 this cycle
        cycle(0, 1, 0, 1);              // mem_ready ignored outside memory states
        cycle(0, 1, 0, 10);
        cycle(0, 1, 0, 11);

        cur_test = "rtype";
        fetch(6'b000000, 6'b100000);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 6);
        cycle(0, 0, 0, 7);

        cur_test = "lw";
        fetch(6'b100011, 6'b000000);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 2);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 3);
        cycle(0, 1, 0, 3);
        cycle(0, 1, 0, 4);

        cur_test = "sw";
        fetch(6'b101011, 6'b000000);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 2);
        cycle(0, 0, 0, 5);
        cycle(0, 1, 0, 5);

        cur_test = "beq_z1";
        fetch(6'b000100, 6'b000000);
        cycle(0, 0, 1, 1);
        cycle(0, 0, 1, 8);

        cur_test = "beq_z0";
        fetch(6'b000100, 6'b000000);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 8);

        cur_test = "j";
        fetch(6'b000010, 6'b000000);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 9);

        cur_test = "jal";
        fetch(6'b000011, 6'b000000);
        cycle(0, 0, 0, 1);
`ifdef JAL_JR_EN
        cycle(0, 0, 0, 12);
`else
        cycle(0, 0, 0, 15);
        cycle(1, 0, 0, 15);
`endif

        cur_test = "jr";
        fetch(6'b000000, 6'b001000);
        cycle(0, 0, 0, 1);
`ifdef JAL_JR_EN
        cycle(0, 0, 0, 13);
`else
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 15);
        cycle(1, 0, 0, 15);
`endif

        cur_test = "illegal";
        fetch(6'b111111, 6'b000000);
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 9; i++) cycle(0, 1, 0, 15);
        cycle(1, 0, 0, 15);
        cycle(0, 0, 0, 0);

        cur_test = "rst_mem_wr";
        fetch(6'b101011, 6'b000000);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 2);
        cycle(0, 0, 0, 5);
        cycle(1, 0, 0, 5);
        cycle(0, 0, 0, 0);

        cur_test = "rst_mem_rd";
        fetch(6'b100011, 6'b000000);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 2);
        cycle(1, 0, 0, 3);
        cycle(0, 0, 0, 0);

        cur_test = "drain";
        @(negedge clk);
        @(negedge clk);
        check("drain:queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
